// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback/commit stage: entry field widths,
// the x0 index and the RUN/HALT state encoding.
package wb_commit_pkg;

  localparam int XLEN_DEF = 64;
  localparam int CSR_AW_DEF = 12;
  localparam int RD_W = 5;
  localparam int FLAG_W = 1;
  localparam logic [RD_W-1:0] X0_IDX = '0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Packed entry layout, MSB first: wen, rd, wdata, csr_wen, csr_addr, csr_wdata, exit, pc.
  function automatic int entry_width(input int xlen, input int csr_aw);
    return FLAG_W + RD_W + xlen + FLAG_W + csr_aw + xlen + FLAG_W + xlen;
  endfunction

endpackage

// File: rtl/wb_commit_fifo.sv
// Generic DEPTH x W in-order FIFO with async reset and a synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_commit_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Flush wins over push/pop so nothing written in the flush cycle survives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: queues completed instructions, retires one per cycle
// to the regfile/CSR ports, counts retirements and halts on the exit instruction.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = 2,
  parameter int CSR_AW = CSR_AW_DEF,
  parameter int CNT_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              wen_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              csr_wen_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  input  logic              exit_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              stall_i,
  input  logic [XLEN-1:0]   a0_i,
  output logic              wen_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              csr_wen_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              retire_o,
  output logic [XLEN-1:0]   retire_pc_o,
  output logic [CNT_W-1:0]  instret_o,
  output logic              halt_o,
  output logic              good_trap_o,
  output logic [XLEN-1:0]   exit_code_o,
  output logic [XLEN-1:0]   exit_pc_o
);

  localparam int EW = entry_width(XLEN, CSR_AW);

  state_t            state;
  state_t            state_next;
  logic              full;
  logic              empty;
  logic              push;
  logic              fire;
  logic              flush;
  logic              ready;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head_entry;

  logic              head_wen;
  logic [RD_W-1:0]   head_rd;
  logic [XLEN-1:0]   head_wdata;
  logic              head_csr_wen;
  logic [CSR_AW-1:0] head_csr_addr;
  logic [XLEN-1:0]   head_csr_wdata;
  logic              head_exit;
  logic [XLEN-1:0]   head_pc;

  logic [CNT_W-1:0]  instret;
  logic              halted;
  logic              good_trap;
  logic [XLEN-1:0]   exit_code;
  logic [XLEN-1:0]   exit_pc;

  assign push_entry = {wen_i, rd_i, wdata_i, csr_wen_i, csr_addr_i, csr_wdata_i, exit_i, pc_i};
  assign {head_wen, head_rd, head_wdata, head_csr_wen,
          head_csr_addr, head_csr_wdata, head_exit, head_pc} = head_entry;

  assign push = valid_i && ready;

  wb_commit_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (fire),
    .push_data (push_entry),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Retiring the exit entry moves to HALT and drops anything queued behind it.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    fire       = 1'b0;
    flush      = 1'b0;
    case (state)
      ST_RUN: begin
        ready = !full;
        fire  = !empty && !stall_i;
        if (fire && head_exit) begin
          flush      = 1'b1;
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instret   <= '0;
      halted    <= 1'b0;
      good_trap <= 1'b0;
      exit_code <= '0;
      exit_pc   <= '0;
    end else if (fire) begin
      instret <= instret + CNT_W'(1);
      if (head_exit) begin
        halted    <= 1'b1;
        good_trap <= (a0_i == '0);
        exit_code <= a0_i;
        exit_pc   <= head_pc;
      end
    end
  end

  assign ready_o     = ready;
  assign retire_o    = fire;
  assign wen_o       = fire && head_wen && (head_rd != X0_IDX);
  assign rd_o        = fire ? head_rd : '0;
  assign wdata_o     = fire ? head_wdata : '0;
  assign csr_wen_o   = fire && head_csr_wen;
  assign csr_addr_o  = fire ? head_csr_addr : '0;
  assign csr_wdata_o = fire ? head_csr_wdata : '0;
  assign retire_pc_o = fire ? head_pc : '0;
  assign instret_o   = instret;
  assign halt_o      = halted;
  assign good_trap_o = good_trap;
  assign exit_code_o = exit_code;
  assign exit_pc_o   = exit_pc;

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Parametrised writeback/commit stage of the RV64IM core, between MEM and the regfile/CSR file.
- Buffers completed instructions in a DEPTH-entry in-order queue with valid/ready handshake toward MEM.
- Retires one instruction per cycle to the regfile and CSR write ports and counts retired instructions.
- Handles the exit instruction with a RUN/HALT state machine; raises halt/exit-code outputs for the testbench instead of ending simulation itself.

Parameters:
- XLEN, 64, data/PC width.
- DEPTH, 2, commit queue entries; power of two, >=2.
- CSR_AW, 12, CSR address width.
- CNT_W, 64, instret counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  MEM presents a completed instruction
- ready_o  out  1  queue accepts this cycle
- wen_i  in  1  regfile write request
- rd_i  in  5  destination register
- wdata_i  in  XLEN  regfile write data
- csr_wen_i  in  1  CSR write request
- csr_addr_i  in  CSR_AW  CSR address
- csr_wdata_i  in  XLEN  CSR write data
- exit_i  in  1  instruction is the simulation-exit instruction
- pc_i  in  XLEN  instruction PC
- stall_i  in  1  freeze commit this cycle (regfile/CSR port busy)
- a0_i  in  XLEN  current regfile x10
- wen_o  out  1  regfile write strobe
- rd_o  out  5  regfile write index
- wdata_o  out  XLEN  regfile write data
- csr_wen_o  out  1  CSR write strobe
- csr_addr_o  out  CSR_AW  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- retire_o  out  1  one instruction retired this cycle
- retire_pc_o  out  XLEN  PC of retiring instruction
- instret_o  out  CNT_W  retired-instruction count
- halt_o  out  1  core halted after exit
- good_trap_o  out  1  exit with a0 == 0
- exit_code_o  out  XLEN  a0 captured at exit
- exit_pc_o  out  XLEN  PC of exit instruction

Behaviour:
- Reset (async, immediate, also mid-operation): queue empty, pointers 0, state RUN, instret 0, halt/good_trap/exit_code/exit_pc 0. All strobes and data outputs read 0 while reset is held.
- Queue: read/write pointers carry an extra wrap bit. Empty when the pointers are equal. Full when indices are equal and wrap bits differ. Wrap-around at DEPTH.
- ready_o = !full && state==RUN.
- push = valid_i && ready_o. No push when full; no full-bypass.
- fire = !empty && !stall_i && state==RUN. fire pops the head.
- Commit outputs are combinational from the head entry, qualified by fire:
  - retire_o = fire.
  - wen_o = fire && head.wen && head.rd != 0 (x0 writes suppressed).
  - csr_wen_o = fire && head.csr_wen.
  - Data/address outputs show head fields when fire, else 0.
- Latency: an entry accepted at edge k is committable in the cycle after k. Back-to-back throughput is 1/cycle with DEPTH >= 2.
- Simultaneous push and pop: legal at any non-full occupancy. Count unchanged.
- instret: +1 on each fire, wraps modulo 2^CNT_W.
- FSM RUN -> HALT when fire && head.exit:
  - Exit entry's own regfile/CSR writes are still performed and counted.
  - Capture exit_code <= a0_i, exit_pc <= head.pc, good_trap <= (a0_i == 0), halt <= 1.
  - a0_i reflects all earlier commits.
- HALT is terminal until reset: ready_o = 0, fire = 0, remaining queue entries discarded (pointers cleared on entry to HALT), instret frozen, exit outputs held.
- stall_i in HALT has no effect. stall_i in RUN holds the head; queue fills and ready_o drops at full.

Decomposition:
- Shared package (core defines):
  - Commit-entry field widths.
  - x0 index constant.
  - FSM state encoding: RUN = 0, HALT = 1.
  - XLEN default.
- One sub-module: wb_commit_fifo, a generic DEPTH x W synchronous FIFO with async reset, flush, push/pop, full/empty. wb_commit packs and unpacks entry fields and owns the FSM and counter.

Test Plan:
- Reset, then push wen=1, rd=5, wdata=0x1234, pc=0x80000000 -> next cycle wen_o=1, rd_o=5, wdata_o=0x1234, retire_pc_o=0x80000000, instret_o=1.
- Push wen=1, rd=0, wdata=0xFF -> wen_o=0, retire_o=1, instret_o increments.
- Hold stall_i=1, offer 3 valid entries (DEPTH=2) -> first 2 accepted, ready_o=0 on the third. Release stall -> commits occur in order on consecutive cycles, ready_o reasserts.
- Exit entry with a0_i=0, pc=0x80000100 -> halt_o=1, good_trap_o=1, exit_pc_o=0x80000100. ready_o stays 0 and instret_o is frozen over the next 10 cycles of valid_i=1.
- Exit with a0_i=0x3 while one entry is still queued behind it -> good_trap_o=0, exit_code_o=0x3, the queued entry never retires.
- Assert reset mid-stream with a full queue -> outputs 0 and ready_o=1 immediately after deassertion, instret_o=0, halt_o=0.
